// File: rtl/alu_result_stage.sv
// Result stage behind the 64-bit EX ALU: 2-entry skid buffer toward MEM/WB plus committed NZCV.
// Optional commit/overflow counters are enabled by defining ALU_RESULT_STATS_EN.
module alu_result_stage #(
   parameter int DATA_W = 64,
   parameter int CTL_W  = 11,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTL_W-1:0]  in_aluctl,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_zero,
   input  logic              in_overflow,
   input  logic              in_carryout,
   input  logic              in_set_flags,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_wb_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [CTL_W-1:0]  out_aluctl,
   output logic [REG_W-1:0]  out_rd,
   output logic              out_wb_en,
   output logic              out_zero,
`ifdef ALU_RESULT_STATS_EN
   output logic [31:0]       stat_commits,
   output logic [31:0]       stat_overflows,
`endif
   output logic [3:0]        flags_nzcv
);

   typedef struct packed {
      logic [CTL_W-1:0]  aluctl;
      logic [DATA_W-1:0] result;
      logic              zero;
      logic              overflow;
      logic              carryout;
      logic              set_flags;
      logic [REG_W-1:0]  rd;
      logic              wb_en;
   } entry_t;

   entry_t     main_q, main_d, skid_q, skid_d, in_entry;
   logic [1:0] occ_q, occ_d;
   logic       in_ready_q, in_ready_d;
   logic [3:0] nzcv_q, nzcv_d;
   logic       acc, com;

   always_comb begin
      in_entry.aluctl    = in_aluctl;
      in_entry.result    = in_result;
      in_entry.zero      = in_zero;
      in_entry.overflow  = in_overflow;
      in_entry.carryout  = in_carryout;
      in_entry.set_flags = in_set_flags;
      in_entry.rd        = in_rd;
      in_entry.wb_en     = in_wb_en;
   end

   assign acc = in_valid && in_ready_q;
   assign com = (occ_q != 2'd0) && out_ready;

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      occ_d  = occ_q;
      nzcv_d = nzcv_q;
      if (flush) begin
         occ_d = 2'd0;
      end else begin
         case (occ_q)
            2'd0: begin
               if (acc) begin
                  main_d = in_entry;
                  occ_d  = 2'd1;
               end
            end
            2'd1: begin
               if (acc && com) begin
                  main_d = in_entry;
               end else if (com) begin
                  occ_d = 2'd0;
               end else if (acc) begin
                  skid_d = in_entry;
                  occ_d  = 2'd2;
               end
            end
            default: begin
               // full: in_ready is low, so only a commit can happen here
               if (com) begin
                  main_d = skid_q;
                  occ_d  = 2'd1;
               end
            end
         endcase
         if (com && main_q.set_flags)
            nzcv_d = {main_q.result[DATA_W-1], main_q.zero, main_q.carryout, main_q.overflow};
      end
      in_ready_d = (occ_d != 2'd2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         occ_q      <= 2'd0;
         in_ready_q <= 1'b1;
         nzcv_q     <= 4'b0000;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         occ_q      <= occ_d;
         in_ready_q <= in_ready_d;
         nzcv_q     <= nzcv_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = (occ_q != 2'd0);
   assign out_result = main_q.result;
   assign out_aluctl = main_q.aluctl;
   assign out_rd     = main_q.rd;
   assign out_wb_en  = main_q.wb_en;
   assign out_zero   = main_q.zero;
   assign flags_nzcv = nzcv_q;

`ifdef ALU_RESULT_STATS_EN
   logic [31:0] commits_q, commits_d, ovfs_q, ovfs_d;
   logic        com_eff;

   // a commit in the flush cycle is dropped, so it is not counted
   assign com_eff = com && !flush;

   always_comb begin
      commits_d = commits_q;
      ovfs_d    = ovfs_q;
      if (com_eff && (commits_q != 32'hFFFF_FFFF))
         commits_d = commits_q + 32'd1;
      if (com_eff && main_q.overflow && (ovfs_q != 32'hFFFF_FFFF))
         ovfs_d = ovfs_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         commits_q <= 32'd0;
         ovfs_q    <= 32'd0;
      end else begin
         commits_q <= commits_d;
         ovfs_q    <= ovfs_d;
      end
   end

   assign stat_commits   = commits_q;
   assign stat_overflows = ovfs_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized + directed bench for alu_result_stage with a queue-based reference model.
// Stats checks are active when ALU_RESULT_STATS_EN is defined.
module tb_alu_result_stage;
   localparam int DATA_W = 64;
   localparam int CTL_W  = 11;
   localparam int REG_W  = 5;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [CTL_W-1:0]  in_aluctl, out_aluctl;
   logic [DATA_W-1:0] in_result, out_result;
   logic              in_zero, in_overflow, in_carryout, in_set_flags, in_wb_en;
   logic [REG_W-1:0]  in_rd, out_rd;
   logic              out_wb_en, out_zero;
   logic [3:0]        flags_nzcv;
`ifdef ALU_RESULT_STATS_EN
   logic [31:0]       stat_commits, stat_overflows;
`endif

   alu_result_stage #(.DATA_W(DATA_W), .CTL_W(CTL_W), .REG_W(REG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_aluctl(in_aluctl), .in_result(in_result), .in_zero(in_zero),
      .in_overflow(in_overflow), .in_carryout(in_carryout), .in_set_flags(in_set_flags),
      .in_rd(in_rd), .in_wb_en(in_wb_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_aluctl(out_aluctl), .out_rd(out_rd), .out_wb_en(out_wb_en), .out_zero(out_zero),
`ifdef ALU_RESULT_STATS_EN
      .stat_commits(stat_commits), .stat_overflows(stat_overflows),
`endif
      .flags_nzcv(flags_nzcv)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] result;
      logic [CTL_W-1:0]  ctl;
      logic [REG_W-1:0]  rd;
      logic              wb, z, o, c, sf;
   } exp_t;

   exp_t        q[$];
   logic [3:0]  m_nzcv;
   int unsigned m_commits, m_ovfs;
   int          errors = 0;
   int          checks = 0;
   bit          checks_on = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: samples on the falling edge, then advances the model
   // across the coming rising edge using the inputs currently applied.
   initial begin
      exp_t e;
      bit   m_com, m_acc;
      m_nzcv = 4'b0; m_commits = 0; m_ovfs = 0;
      forever begin
         @(negedge clk);
         if (checks_on) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("nzcv", flags_nzcv, m_nzcv);
`ifdef ALU_RESULT_STATS_EN
            chk("stat_commits", stat_commits, m_commits);
            chk("stat_overflows", stat_overflows, m_ovfs);
`endif
         end
         if (rst) begin
            q.delete();
            m_nzcv = 4'b0; m_commits = 0; m_ovfs = 0;
         end else begin
            m_com = (q.size() != 0) && out_ready && !flush;
            m_acc = in_valid && (q.size() < 2) && !flush;
            if (checks_on && out_valid && out_ready && !flush) begin
               if (q.size() == 0) begin
                  chk("commit_unexpected", 1'b1, 1'b0);
               end else begin
                  chk("out_result", out_result, q[0].result);
                  chk("out_aluctl", out_aluctl, q[0].ctl);
                  chk("out_rd", out_rd, q[0].rd);
                  chk("out_wb_en", out_wb_en, q[0].wb);
                  chk("out_zero", out_zero, q[0].z);
               end
            end
            if (m_com) begin
               e = q.pop_front();
               if (e.sf) m_nzcv = {e.result[DATA_W-1], e.z, e.c, e.o};
               if (m_commits != 32'hFFFF_FFFF) m_commits++;
               if (e.o && m_ovfs != 32'hFFFF_FFFF) m_ovfs++;
            end
            if (flush) q.delete();
            if (m_acc) begin
               e.result = in_result; e.ctl = in_aluctl; e.rd = in_rd; e.wb = in_wb_en;
               e.z = in_zero; e.o = in_overflow; e.c = in_carryout; e.sf = in_set_flags;
               q.push_back(e);
            end
         end
      end
   end

   // Applies one cycle of stimulus just after a rising edge; acc tells the
   // caller whether the op was taken at the next edge.
   task automatic drive(input bit v, input bit r, input bit f, input logic [63:0] res,
                        input bit z, input bit o, input bit c, input bit sf, output bit acc);
      in_valid = v; out_ready = r; flush = f;
      in_result = res; in_zero = z; in_overflow = o; in_carryout = c; in_set_flags = sf;
      in_aluctl = CTL_W'($urandom); in_rd = REG_W'($urandom); in_wb_en = 1'($urandom);
      acc = v && in_ready && !f;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bit d;
      for (int i = 0; i < n; i++) drive(0, 1, 0, 64'h0, 0, 0, 0, 0, d);
   endtask

   initial begin
      bit d, got;
      rst = 1; flush = 0; in_valid = 0; out_ready = 0;
      in_aluctl = '0; in_result = '0; in_zero = 0; in_overflow = 0; in_carryout = 0;
      in_set_flags = 0; in_rd = '0; in_wb_en = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_nzcv", flags_nzcv, 4'b0000);
      chk("rst_out_result", out_result, 64'h0);
      chk("rst_out_aluctl", out_aluctl, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_wb_en", out_wb_en, 0);
      chk("rst_out_zero", out_zero, 0);
      checks_on = 1;
      @(posedge clk); #1;

      // single op: +5, carry set
      drive(1, 1, 0, 64'h5, 0, 0, 1, 1, d);
      idle(2);
      chk("single_nzcv", flags_nzcv, 4'b0010);

      // backpressure: A, B fill the buffer, C waits until space opens
      drive(1, 0, 0, 64'hA, 0, 0, 0, 0, d);
      drive(1, 0, 0, 64'hB, 0, 0, 0, 0, d);
      got = 0;
      for (int k = 0; k < 10 && !got; k++) drive(1, k >= 2, 0, 64'hC, 0, 0, 0, 0, got);
      chk("bp_c_accepted", got, 1'b1);
      idle(4);

      // negative flag-setting result, then a non-flag-setting op
      drive(1, 1, 0, 64'h8000_0000_0000_0000, 0, 1, 0, 1, d);
      drive(1, 1, 0, 64'h0, 1, 0, 0, 0, d);
      idle(3);
      chk("neg_nzcv", flags_nzcv, 4'b1001);

      // flush at occupancy 2 with a new op presented
      drive(1, 0, 0, 64'h11, 1, 1, 1, 1, d);
      drive(1, 0, 0, 64'h22, 0, 1, 0, 1, d);
      drive(1, 1, 1, 64'h33, 0, 0, 1, 1, d);
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_in_ready", in_ready, 1'b1);
      chk("flush_nzcv", flags_nzcv, 4'b1001);
      idle(3);

      // randomized traffic
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 4,
               {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), d);
      idle(4);

      // reset in the middle of traffic
      drive(1, 0, 0, 64'hDEAD, 1, 1, 1, 1, d);
      drive(1, 0, 0, 64'hBEEF, 1, 1, 1, 1, d);
      rst = 1;
      drive(1, 1, 1, 64'h1234, 1, 1, 1, 1, d);
      rst = 0;
      in_valid = 0; flush = 0;
      @(negedge clk);
      chk("mrst_out_result", out_result, 64'h0);
      chk("mrst_out_rd", out_rd, 0);
      chk("mrst_out_zero", out_zero, 0);
      @(posedge clk); #1;
      drive(1, 1, 0, 64'h7, 0, 1, 0, 1, d);
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream neighbour of the 64-bit EX-stage ALU.
- Registers the ALU result and its Zero/Overflow/Carryout flags, plus destination tag, into a 2-entry skid buffer with valid/ready handshakes toward the MEM/WB side.
- Maintains the architectural NZCV flag register, updated in commit order for flag-setting ops.
- Decouples the combinational ALU from downstream stalls without a combinational ready path.

Parameters:
DATA_W, 64, ALU result width
CTL_W, 11, ALU control/opcode width
REG_W, 5, destination register index width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  discard all buffered entries (branch mispredict/exception)
in_valid  input  1  ALU output valid this cycle
in_ready  output  1  stage can accept; registered, not derived from out_ready
in_aluctl  input  CTL_W  ALU control word of the op
in_result  input  DATA_W  ALU result
in_zero  input  1  ALU Zero
in_overflow  input  1  ALU Overflow
in_carryout  input  1  ALU Carryout
in_set_flags  input  1  op updates NZCV (ADDS/SUBS/ANDS)
in_rd  input  REG_W  destination register
in_wb_en  input  1  op writes register file
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head
out_result  output  DATA_W  head result
out_aluctl  output  CTL_W  head control word
out_rd  output  REG_W  head destination
out_wb_en  output  1  head write enable
out_zero  output  1  head Zero flag (for CBZ/CBNZ)
flags_nzcv  output  4  committed {N,Z,C,V}

Behaviour:
- Accept: in_valid && in_ready at the rising edge. Commit: out_valid && out_ready at the rising edge.
- Storage: main entry (drives out_*) and skid entry. Occupancy is 0..2.
- Latency: an accepted op appears on out_* the next cycle when occupancy was 0, or when it was 1 and the head commits in the same cycle.
- Ordering: FIFO. The skid entry moves to main on commit. No bypass from in_* to out_*.
- in_ready = (occupancy < 2), registered. It deasserts the cycle after the skid entry fills, i.e. on the edge that takes occupancy to 2.
- Occupancy 2 with a commit: the skid entry moves to main and in_ready rises the next cycle. Any in_valid presented while in_ready is low is ignored.
- Simultaneous accept + commit at occupancy 1: the new op goes to main and the skid entry stays empty.
- Simultaneous accept + commit at occupancy 2: impossible, because in_ready is low.
- NZCV update on commit, when the committed entry has set_flags=1:
  - N = result[DATA_W-1]
  - Z = zero
  - C = carryout
  - V = overflow
- Entries with set_flags=0 leave NZCV unchanged.
- Flush (highest priority after rst):
  - Occupancy becomes 0 and out_valid=0 next cycle.
  - An accept and a commit in the flush cycle are both dropped. NZCV is not updated by a commit coinciding with flush.
  - NZCV otherwise keeps its value.
  - in_ready=1 next cycle.
- out_* payload when out_valid=0: holds last value and carries no meaning.
- Reset (rst=1 at an edge, including mid-operation):
  - occupancy 0, out_valid=0, in_ready=1, flags_nzcv=4'b0000
  - out_result=0, out_aluctl=0, out_rd=0, out_wb_en=0, out_zero=0
  - Reset overrides flush and all handshakes.

Optional Feature:
- Macro ALU_RESULT_STATS_EN. When defined, add outputs:
  - stat_commits  (32 bits)  count of committed ops
  - stat_overflows  (32 bits)  count of committed ops with overflow=1
- Both counters saturate at 32'hFFFFFFFF, reset to 0 on rst, and are unaffected by flush. Flushed entries are never counted.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> out_valid=0, in_ready=1, flags_nzcv=0000, out_result=0.
- Single op: in_result=64'h5 with set_flags=1, zero=0, carry=1, ovf=0, out_ready=1 -> next cycle out_valid=1, out_result=5. After commit, NZCV=0010.
- Backpressure: out_ready=0, three back-to-back in_valid ops A,B,C -> A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready -> A, B, C emerge in order with no loss or duplication.
- Negative flag-setting result 64'h8000000000000000, overflow=1 -> NZCV=1001. A following op with set_flags=0 and result 0 -> NZCV stays 1001.
- Flush at occupancy 2 with in_valid=1 -> next cycle out_valid=0, in_ready=1, NZCV unchanged, dropped ops never appear.
- ALU_RESULT_STATS_EN defined: 5 commits, 2 with overflow, plus 1 flushed op -> stat_commits=5, stat_overflows=2.
